// File: rtl/game_engine.sv
// 2048 engine: slides one line per cycle, spawns from a free-running LFSR,
// then evaluates win/game-over. Cells hold log2 exponents (0 = empty).
module game_engine #(
  parameter int          N       = 4,
  parameter int          EXP_W   = 4,
  parameter int          SCORE_W = 24,
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  output logic                   move_ready,
  input  logic                   new_game,
  input  logic                   load_valid,
  input  logic [N*N*EXP_W-1:0]   load_board,
  output logic [N*N*EXP_W-1:0]   board,
  output logic [SCORE_W-1:0]     score,
  output logic                   last_move_valid,
  output logic                   won,
  output logic                   game_over
);
  localparam int NN     = N * N;
  localparam int BW     = NN * EXP_W;
  localparam int IDX_W  = $clog2(NN);
  localparam int LINE_W = $clog2(N);
  localparam logic [EXP_W-1:0] MAX_EXP = '1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SLIDE, S_SPAWN, S_CHECK} state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       board_q, board_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [1:0]          dir_q, dir_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                changed_q, changed_d;
  logic                lmv_q, lmv_d;
  logic                won_q, won_d;
  logic                go_q, go_d;
  logic                scan_active_q, scan_active_d;
  logic [IDX_W-1:0]    pos_q, pos_d;
  logic                init_second_q, init_second_d;

  logic [EXP_W-1:0]    seq  [N];
  logic [EXP_W-1:0]    comp [N+1];
  logic [EXP_W-1:0]    res  [N];
  int unsigned         cnt, o, sh;
  logic                skip;
  logic [SCORE_W:0]    sum_w;
  logic [SCORE_W-1:0]  slide_score;
  logic                line_changed;
  logic                last_line;

  logic [IDX_W-1:0]    start_idx, scan_idx;
  logic                scan_empty;
  logic [EXP_W-1:0]    spawn_val;
  logic                full, pair, win_hit;

  // Cell index of position j (0 = head) within the given line for a direction.
  function automatic int unsigned cell_idx(input logic [1:0] dir, input int unsigned line,
                                           input int unsigned j);
    case (dir)
      2'b00:   return j * N + line;
      2'b01:   return line * N + (N - 1 - j);
      2'b10:   return (N - 1 - j) * N + line;
      default: return line * N + j;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q       <= '0;
      score_q       <= '0;
      lfsr_q        <= SEED;
      dir_q         <= '0;
      line_q        <= '0;
      changed_q     <= 1'b0;
      lmv_q         <= 1'b0;
      won_q         <= 1'b0;
      go_q          <= 1'b0;
      scan_active_q <= 1'b0;
      pos_q         <= '0;
      init_second_q <= 1'b0;
    end else begin
      board_q       <= board_d;
      score_q       <= score_d;
      lfsr_q        <= lfsr_d;
      dir_q         <= dir_d;
      line_q        <= line_d;
      changed_q     <= changed_d;
      lmv_q         <= lmv_d;
      won_q         <= won_d;
      go_q          <= go_d;
      scan_active_q <= scan_active_d;
      pos_q         <= pos_d;
      init_second_q <= init_second_d;
    end
  end

  // Slide of the current line: compact, merge from the head once per pair, repack.
  always_comb begin
    seq          = '{default: '0};
    comp         = '{default: '0};
    res          = '{default: '0};
    cnt          = 0;
    o            = 0;
    sh           = 0;
    skip         = 1'b0;
    sum_w        = '0;
    slide_score  = score_q;
    line_changed = 1'b0;
    for (int unsigned j = 0; j < N; j++)
      seq[j] = board_q[cell_idx(dir_q, 32'(line_q), j)*EXP_W +: EXP_W];
    for (int unsigned j = 0; j < N; j++) begin
      if (seq[j] != '0) begin
        comp[cnt] = seq[j];
        cnt++;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != '0) begin
        if (comp[j] == comp[j+1] && comp[j] != MAX_EXP) begin
          res[o] = comp[j] + EXP_W'(1);
          skip   = 1'b1;
          sh     = 32'(comp[j]) + 1;
          if (sh >= SCORE_W) begin
            slide_score = '1;
          end else begin
            sum_w       = {1'b0, slide_score} + ((SCORE_W+1)'(1) << sh);
            slide_score = sum_w[SCORE_W] ? '1 : sum_w[SCORE_W-1:0];
          end
        end else begin
          res[o] = comp[j];
        end
        o++;
      end
    end
    for (int unsigned j = 0; j < N; j++)
      if (res[j] != seq[j]) line_changed = 1'b1;
  end

  always_comb begin
    start_idx  = IDX_W'(lfsr_q % 16'(NN));
    scan_idx   = scan_active_q ? pos_q : start_idx;
    scan_empty = board_q[32'(scan_idx)*EXP_W +: EXP_W] == '0;
    spawn_val  = (lfsr_q[3:0] == 4'd0) ? EXP_W'(2) : EXP_W'(1);
    last_line  = line_q == LINE_W'(N - 1);
    full       = 1'b1;
    pair       = 1'b0;
    win_hit    = 1'b0;
    for (int unsigned i = 0; i < NN; i++) begin
      if (board_q[i*EXP_W +: EXP_W] == '0) full = 1'b0;
      if (32'(board_q[i*EXP_W +: EXP_W]) >= WIN_EXP) win_hit = 1'b1;
    end
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (c + 1 < N && board_q[(r*N+c)*EXP_W +: EXP_W] == board_q[(r*N+c+1)*EXP_W +: EXP_W])
          pair = 1'b1;
        if (r + 1 < N && board_q[(r*N+c)*EXP_W +: EXP_W] == board_q[((r+1)*N+c)*EXP_W +: EXP_W])
          pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (scan_empty && init_second_q) state_d = S_CHECK;
      S_IDLE: begin
        if (new_game)                state_d = S_INIT;
        else if (load_valid)         state_d = S_CHECK;
        else if (move_valid && !go_q) state_d = S_SLIDE;
      end
      S_SLIDE: if (last_line) state_d = (changed_q || line_changed) ? S_SPAWN : S_IDLE;
      S_SPAWN: if (scan_empty) state_d = S_CHECK;
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    board_d       = board_q;
    score_d       = score_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    dir_d         = dir_q;
    line_d        = line_q;
    changed_d     = changed_q;
    lmv_d         = lmv_q;
    won_d         = won_q;
    go_d          = go_q;
    scan_active_d = scan_active_q;
    pos_d         = pos_q;
    init_second_d = init_second_q;
    case (state_q)
      S_INIT, S_SPAWN: begin
        if (scan_empty) begin
          board_d[32'(scan_idx)*EXP_W +: EXP_W] = spawn_val;
          scan_active_d = 1'b0;
          if (state_q == S_INIT) init_second_d = 1'b1;
        end else begin
          scan_active_d = 1'b1;
          pos_d = (scan_idx == IDX_W'(NN - 1)) ? '0 : scan_idx + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (new_game || load_valid) begin
          board_d       = new_game ? '0 : load_board;
          score_d       = '0;
          won_d         = 1'b0;
          go_d          = 1'b0;
          lmv_d         = 1'b0;
          init_second_d = 1'b0;
          scan_active_d = 1'b0;
        end else if (move_valid && !go_q) begin
          dir_d     = move_dir;
          line_d    = '0;
          changed_d = 1'b0;
        end
      end
      S_SLIDE: begin
        for (int unsigned j = 0; j < N; j++)
          board_d[cell_idx(dir_q, 32'(line_q), j)*EXP_W +: EXP_W] = res[j];
        score_d   = slide_score;
        changed_d = changed_q | line_changed;
        line_d    = line_q + LINE_W'(1);
        if (last_line) lmv_d = changed_q | line_changed;
      end
      S_CHECK: begin
        go_d  = full && !pair;
        won_d = won_q | win_hit;
      end
      default: ;
    endcase
  end

  always_comb begin
    move_ready      = (state_q == S_IDLE) && !go_q;
    board           = board_q;
    score           = score_q;
    last_move_valid = lmv_q;
    won             = won_q;
    game_over       = go_q;
  end
endmodule

// File: doc/game_engine.md
# game_engine

Clocked, parametrised 2048 game engine for an N×N grid. It accepts one move per handshake and slides/merges the grid one line per cycle. It then spawns a tile from a free-running LFSR and checks win/game-over. Tiles are stored as log2 exponents (0 = empty, k = 2^k), and the board bus feeds the display/renderer directly.

## Interface
- `N`, default 4: grid dimension (2..8)
- `EXP_W`, default 4: bits per cell exponent
- `SCORE_W`, default 24: score width
- `WIN_EXP`, default 11: exponent that sets `won` (2048)
- `SEED`, default 16'hACE1: LFSR reset value (must be nonzero)

Ports:
- `clk`  in  1: single clock, all state on rising edge
- `rst`  in  1: asynchronous, active-low reset
- `move_valid`  in  1: move request
- `move_dir`  in  2: 00 up (toward row 0), 01 right, 10 down, 11 left
- `move_ready`  out  1: engine accepts a move this cycle
- `new_game`  in  1: pulse; clear and restart
- `load_valid`  in  1: verification preload strobe
- `load_board`  in  N*N*EXP_W: preload image
- `board`  out  N*N*EXP_W: cell (r,c) at `[(r*N+c)*EXP_W +: EXP_W]`, registered
- `score`  out  SCORE_W: accumulated score
- `last_move_valid`  out  1: last accepted move changed the board
- `won`  out  1: sticky, any cell ≥ WIN_EXP
- `game_over`  out  1: no empty cell and no equal orthogonal neighbours

## Operation
- States:
  - INIT: spawn two tiles.
  - IDLE: `move_ready = !game_over`.
  - SLIDE: process one line per cycle.
  - SPAWN: place one tile.
  - CHECK: evaluate game-over and win.
- Handshake: a move is accepted when `move_valid && move_ready`. `move_dir` is captured at acceptance and `move_valid` is ignored outside acceptance.
- SLIDE, line i (i = 0..N-1):
  - Lines are rows for left/right and columns for up/down.
  - Head is the `move_dir` side.
  - Drop zeros, then merge equal adjacent pairs scanning from the head; each result merges at most once.
  - Pack toward the head and zero-fill.
  - A merge of k gives k+1 and adds 2^(k+1) to `score`, saturating at all-ones.
  - Cells at 2^EXP_W−1 never merge.
  - A per-move `changed` flag ORs line differences.
- After N SLIDE cycles:
  - If `changed`: go to SPAWN and set `last_move_valid = 1`.
  - Otherwise: set `last_move_valid = 0` and return to IDLE with no spawn.
- SPAWN:
  - Start index = LFSR mod N*N.
  - Scan one cell per cycle, wrapping, until an empty cell is found.
  - Write exponent 2 if `lfsr[3:0] == 0`, else 1.
  - An empty cell is guaranteed because `changed` implies one exists.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state.
- CHECK (1 cycle):
  - Set `game_over` if the board is full and no horizontal or vertical equal pair exists.
  - Set `won` if any cell ≥ WIN_EXP. `won` stays set until `new_game` or reset.
- `new_game`: accepted only in IDLE (including while `game_over`). It clears board, score, `won`, `game_over` and `last_move_valid`, then enters INIT.
- `load_valid`: accepted only in IDLE. It sets `board = load_board`, clears score, `won`, `game_over` and `last_move_valid`, then enters CHECK (no spawn).
- Simultaneous inputs in IDLE: priority is `new_game` > `load_valid` > move.

## Timing
- Reset values:
  - `board` = 0, `score` = 0, `move_ready` = 0.
  - `last_move_valid` = 0, `won` = 0, `game_over` = 0.
  - LFSR = SEED, state = INIT.
- Reset asserted mid-operation returns all of the above to reset values immediately, with no partial update retained.
- INIT: two SPAWN sequences, then CHECK. Latency is ≤ 2·N·N + 1 cycles after reset release.
- Move with no change: `move_ready` is low for N cycles and returns high on cycle N+1 after acceptance.
- Move with change: N (SLIDE) + 1..N·N (SPAWN) + 1 (CHECK) cycles, then IDLE.
- `board` updates at the end of each SLIDE cycle, the SPAWN write cycle and the load cycle. `score` updates in the same cycle as its merge.
- `game_over` and `won` update only in CHECK. `last_move_valid` updates when SLIDE ends.
- `new_game` or `load_valid` asserted while busy is ignored and not latched.

## Test plan
- Reset release:
  - ≤ 2·N·N+1 cycles later `move_ready = 1`.
  - Exactly two nonzero cells, each 1 or 2; `score = 0`.
- Load row0 = [1,1,1,1] (rest 0), move left (11):
  - Row0 = [2,2,0,0], `score = 8`, `last_move_valid = 1`.
  - Exactly 3 nonzero cells, the new one in a previously empty position.
- Load row0 = [1,1,2,0], move left:
  - Row0 = [2,2,0,0] (no double merge), `score = 4`.
  - Same image, move right: row0 = [0,0,2,2].
- Load row0 = [1,2,3,4] (rest 0), move left:
  - Board unchanged, `score = 0`, `last_move_valid = 0`.
  - `move_ready` high again exactly N+1 cycles after acceptance.
- Load full checkerboard of 1/2:
  - Next cycle `game_over = 1`, `move_ready = 0`; moves are ignored.
  - `new_game` → INIT, `game_over = 0`, two tiles.
- Load cell(0,0)=15 and cell(0,1)=15 with EXP_W=4, plus cell(3,3)=11:
  - `won = 1` after CHECK.
  - Move left gives no merge of the 15s; `score` unchanged.
  - Assert `rst` mid-SLIDE → all outputs read reset values.
